// File: rtl/order_pkg.sv
// ============================================================================
// order_pkg : order word layout, opcodes and defaults shared by order_queue.
// Rev 1.0
// ============================================================================
`default_nettype none

package order_pkg;

  localparam int ORDER_W_DEFAULT = 256;

  localparam int FLD_OPCODE_LSB     = 0;
  localparam int FLD_OPCODE_W       = 3;
  localparam int FLD_FIN_BASE_LSB   = 3;
  localparam int FLD_FIN_BASE_W     = 32;
  localparam int FLD_FOUT_BASE_LSB  = 35;
  localparam int FLD_FOUT_BASE_W    = 32;
  localparam int FLD_WEIGHT_LSB     = 67;
  localparam int FLD_WEIGHT_W       = 32;
  localparam int FLD_BIAS_LSB       = 99;
  localparam int FLD_BIAS_W         = 32;
  localparam int FLD_IN_PATCH_LSB   = 131;
  localparam int FLD_IN_PATCH_W     = 16;
  localparam int FLD_OUT_PATCH_LSB  = 147;
  localparam int FLD_OUT_PATCH_W    = 16;
  localparam int FLD_QUANT_IN_LSB   = 163;
  localparam int FLD_QUANT_IN_W     = 8;
  localparam int FLD_QUANT_OUT_LSB  = 171;
  localparam int FLD_QUANT_OUT_W    = 8;
  localparam int FLD_KERNEL_LSB     = 179;
  localparam int FLD_KERNEL_W       = 4;
  localparam int FLD_STRIDE_LSB     = 183;
  localparam int FLD_STRIDE_W       = 4;
  localparam int FLD_RSVD_LSB       = 187;
  localparam int FLD_RSVD_W         = 37;
  localparam int FLD_ID_LSB         = 224;
  localparam int FLD_ID_W           = 32;

  localparam logic [2:0] OP_CONV     = 3'd0;
  localparam logic [2:0] OP_DWCONV   = 3'd1;
  localparam logic [2:0] OP_POOL     = 3'd2;
  localparam logic [2:0] OP_FC       = 3'd3;
  localparam logic [2:0] OP_ADD      = 3'd4;
  localparam logic [2:0] OP_UPSAMPLE = 3'd5;
  localparam logic [2:0] OP_NOP      = 3'd7;

  typedef struct packed {
    logic [31:0] id;
    logic [36:0] reserved;
    logic [3:0]  stride;
    logic [3:0]  kernel;
    logic [7:0]  quant_out;
    logic [7:0]  quant_in;
    logic [15:0] out_patch_num;
    logic [15:0] in_patch_num;
    logic [31:0] bias_base_addr;
    logic [31:0] weight_base_addr;
    logic [31:0] feature_output_base_addr;
    logic [31:0] feature_input_base_addr;
    logic [2:0]  opcode;
  } order_t;

endpackage

`default_nettype wire

// File: rtl/order_queue_ram.sv
// ============================================================================
// order_queue_ram : simple dual-port RAM, registered read, new-data forwarding.
// Rev 1.0   (second read port with ORDER_QUEUE_PEEK_EN)
// ============================================================================
`default_nettype none

module order_queue_ram
  import order_pkg::*;
#(
  parameter int WIDTH = ORDER_W_DEFAULT,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
`ifdef ORDER_QUEUE_PEEK_EN
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
`endif
  output logic [WIDTH-1:0] rd_data
);

  // Indexed by the full wrap-around pointer; at most DEPTH-1 slots are live.
  logic [WIDTH-1:0] mem [DEPTH];

  // A word written on the same edge it is read is forwarded, so the head can
  // be refilled from an entry written just one cycle earlier.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`ifdef ORDER_QUEUE_PEEK_EN
    rd_data_b <= (wr_en && (wr_addr == rd_addr_b)) ? wr_data : mem[rd_addr_b];
`endif
  end

endmodule

`default_nettype wire

// File: rtl/order_queue.sv
// ============================================================================
// order_queue : FWFT order FIFO, RAM plus prefetched head register.
// Rev 1.0   (optional peek port: define ORDER_QUEUE_PEEK_EN)
// ============================================================================
`default_nettype none

module order_queue
  import order_pkg::*;
#(
  parameter int ORDER_W   = ORDER_W_DEFAULT,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int ID_LSB    = FLD_ID_LSB
) (
  input  logic                   system_clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ORDER_W-1:0]     in_order,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ORDER_W-1:0]     out_order,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   empty,
`ifdef ORDER_QUEUE_PEEK_EN
  output logic                   peek_valid,
  output logic [ORDER_W-1:0]     peek_order,
`endif
  output logic                   pop_valid_r,
  output logic [31:0]            pop_id_r
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] TWO        = CW'(2);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      rd_ptr_next;
  logic [ORDER_W-1:0] ram_rdata;
  logic               push;
  logic               pop;
  logic               ram_empty;
  logic               head_load;
  logic               ram_adv;
  logic               ram_we;
  logic               pop_d;
  logic [31:0]        pop_id_d;

  always_comb begin
    in_ready    = count < FULL_COUNT;
    out_valid   = count != '0;
    empty       = count == '0;
    almost_full = count >= AF_COUNT;
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    // The head holds one entry, so the RAM is empty while count < 2.
    ram_empty   = count < TWO;
    head_load   = pop || !out_valid;
    ram_adv     = head_load && !ram_empty;
    // With nothing behind the head, an incoming word goes straight to it.
    ram_we      = push && !flush && !(head_load && ram_empty);
    rd_ptr_next = (rst || flush) ? '0 : rd_ptr + AW'(ram_adv);
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_order   <= '0;
      pop_d       <= 1'b0;
      pop_id_d    <= '0;
      pop_valid_r <= 1'b0;
      pop_id_r    <= '0;
    end else begin
      pop_valid_r <= pop_d;
      if (pop_d) pop_id_r <= pop_id_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        pop_d  <= 1'b0;
      end else begin
        rd_ptr <= rd_ptr_next;
        if (ram_we) wr_ptr <= wr_ptr + PTR_ONE;
        count <= count + CW'(push) - CW'(pop);
        if (head_load && !ram_empty) out_order <= ram_rdata;
        else if (head_load && push)  out_order <= in_order;
        pop_d <= pop;
        if (pop) pop_id_d <= out_order[ID_LSB +: 32];
      end
    end
  end

`ifdef ORDER_QUEUE_PEEK_EN
  // The successor slot gets its own port so the head refill mux stays off it.
  always_comb peek_valid = count >= TWO;
`endif

  order_queue_ram #(
    .WIDTH (ORDER_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (system_clk),
    .wr_en     (ram_we),
    .wr_addr   (wr_ptr),
    .wr_data   (in_order),
    .rd_addr   (rd_ptr_next),
`ifdef ORDER_QUEUE_PEEK_EN
    .rd_addr_b (rd_ptr_next),
    .rd_data_b (peek_order),
`endif
    .rd_data   (ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_order_queue.sv
// ============================================================================
// tb_order_queue : directed table plus model-checked sequences for order_queue.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_order_queue;

  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 2;
  localparam int W         = 256;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_order;
  logic          in_ready, out_valid, almost_full, empty, pop_valid_r;
  logic [W-1:0]  out_order;
  logic [4:0]    count;
  logic [31:0]   pop_id_r;
`ifdef ORDER_QUEUE_PEEK_EN
  logic          peek_valid;
  logic [W-1:0]  peek_order;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  order_queue #(
    .ORDER_W   (W),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN),
    .ID_LSB    (224)
  ) dut (
    .system_clk  (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_order    (in_order),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_order   (out_order),
    .count       (count),
    .almost_full (almost_full),
    .empty       (empty),
`ifdef ORDER_QUEUE_PEEK_EN
    .peek_valid  (peek_valid),
    .peek_order  (peek_order),
`endif
    .pop_valid_r (pop_valid_r),
    .pop_id_r    (pop_id_r)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    int          cnt;
    logic        ov;
    logic [31:0] hid;
    logic        pvr;
    logic [31:0] pid;
  } vec_t;

  // Reference model state
  logic [31:0]  mq[$];
  logic [W-1:0] m_head;
  logic         m_s1v, m_pvr;
  logic [31:0]  m_s1id, m_pid;

  function automatic logic [W-1:0] make_order(input logic [31:0] id);
    return {id, {7{id ^ 32'hA5A5_0000}}};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic fl, input logic iv, input logic [31:0] id, input logic ordy);
    logic       m_push, m_pop;
    logic [31:0] hid;
    @(negedge clk);
    flush = fl; in_valid = iv; in_order = make_order(id); out_ready = ordy;
    m_push = !fl && iv && (mq.size() < DEPTH);
    m_pop  = !fl && ordy && (mq.size() > 0);
    hid    = (mq.size() > 0) ? mq[0] : 32'h0;
    @(posedge clk);
    m_pvr = m_s1v;
    if (m_s1v) m_pid = m_s1id;
    m_s1v  = m_pop;
    m_s1id = hid;
    if (fl) mq.delete();
    else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(id);
    end
    if (mq.size() > 0) m_head = make_order(mq[0]);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"},     W'(count),       W'(mq.size()));
    chk({tag, ".out_valid"}, W'(out_valid),   W'(mq.size() > 0));
    chk({tag, ".out_order"}, out_order,       m_head);
    chk({tag, ".in_ready"},  W'(in_ready),    W'(mq.size() < DEPTH));
    chk({tag, ".afull"},     W'(almost_full), W'(mq.size() >= DEPTH - AF_MARGIN));
    chk({tag, ".empty"},     W'(empty),       W'(mq.size() == 0));
    chk({tag, ".pop_valid"}, W'(pop_valid_r), W'(m_pvr));
    chk({tag, ".pop_id"},    W'(pop_id_r),    W'(m_pid));
`ifdef ORDER_QUEUE_PEEK_EN
    chk({tag, ".peek_valid"}, W'(peek_valid), W'(mq.size() >= 2));
    if (mq.size() >= 2) chk({tag, ".peek_order"}, peek_order, make_order(mq[1]));
`endif
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    m_head = '0; m_s1v = 1'b0; m_pvr = 1'b0; m_s1id = '0; m_pid = '0;
    chk({tag, ".count"},     W'(count),       W'(0));
    chk({tag, ".out_valid"}, W'(out_valid),   W'(0));
    chk({tag, ".out_order"}, out_order,       W'(0));
    chk({tag, ".in_ready"},  W'(in_ready),    W'(1));
    chk({tag, ".empty"},     W'(empty),       W'(1));
    chk({tag, ".afull"},     W'(almost_full), W'(0));
    chk({tag, ".pop_valid"}, W'(pop_valid_r), W'(0));
    chk({tag, ".pop_id"},    W'(pop_id_r),    W'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[15];
    logic [31:0] saved_pid;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_order = '0;
    do_reset("reset");

    //            fl    iv    id      ordy  cnt ov    hid     pvr   pid
    tbl[0]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h11, 1'b0, 2, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h12, 1'b0, 3, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 3, 1'b1, 32'h10, 1'b0, 32'h00};
    tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 2, 1'b1, 32'h11, 1'b0, 32'h00};
    tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1, 1'b1, 32'h12, 1'b1, 32'h10};
    tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 0, 1'b0, 32'h12, 1'b1, 32'h11};
    tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 0, 1'b0, 32'h12, 1'b1, 32'h12};
    tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 0, 1'b0, 32'h12, 1'b0, 32'h12};
    tbl[9]  = '{1'b0, 1'b1, 32'h30, 1'b1, 1, 1'b1, 32'h30, 1'b0, 32'h12};
    tbl[10] = '{1'b0, 1'b1, 32'h31, 1'b1, 1, 1'b1, 32'h31, 1'b0, 32'h12};
    tbl[11] = '{1'b0, 1'b1, 32'h32, 1'b1, 1, 1'b1, 32'h32, 1'b1, 32'h30};
    tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 0, 1'b0, 32'h32, 1'b1, 32'h31};
    tbl[13] = '{1'b0, 1'b0, 32'h00, 1'b0, 0, 1'b0, 32'h32, 1'b1, 32'h32};
    tbl[14] = '{1'b0, 1'b0, 32'h00, 1'b0, 0, 1'b0, 32'h32, 1'b0, 32'h32};

    for (int i = 0; i < 15; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      chk({t, ".count"},     W'(count),       W'(tbl[i].cnt));
      chk({t, ".out_valid"}, W'(out_valid),   W'(tbl[i].ov));
      chk({t, ".out_order"}, out_order,       make_order(tbl[i].hid));
      chk({t, ".in_ready"},  W'(in_ready),    W'(tbl[i].cnt < DEPTH));
      chk({t, ".afull"},     W'(almost_full), W'(tbl[i].cnt >= DEPTH - AF_MARGIN));
      chk({t, ".empty"},     W'(empty),       W'(tbl[i].cnt == 0));
      chk({t, ".pop_valid"}, W'(pop_valid_r), W'(tbl[i].pvr));
      chk({t, ".pop_id"},    W'(pop_id_r),    W'(tbl[i].pid));
    end

    // Fill to the full boundary
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b1, 32'h100 + i, 1'b0);
      check_model($sformatf("fill%0d", i));
    end
    chk("fill13.afull", W'(almost_full), W'(0));
    step(1'b0, 1'b1, 32'h10D, 1'b0);
    chk("fill14.afull", W'(almost_full), W'(1));
    chk("fill14.in_ready", W'(in_ready), W'(1));
    step(1'b0, 1'b1, 32'h10E, 1'b0);
    step(1'b0, 1'b1, 32'h10F, 1'b0);
    chk("fill16.count", W'(count), W'(16));
    chk("fill16.in_ready", W'(in_ready), W'(0));
    step(1'b0, 1'b1, 32'h1FF, 1'b1);
    chk("full_pushpop.count", W'(count), W'(15));
    chk("full_pushpop.head", W'(out_order[255:224]), W'(32'h101));
    step(1'b0, 1'b1, 32'h110, 1'b0);
    check_model("refill");
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check_model($sformatf("drain%0d", i));
    end

    // Steady stream with pointers wrapping repeatedly
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h200 + i, 1'b0);
      check_model($sformatf("prefill%0d", i));
    end
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 32'h205 + i, 1'b1);
      check_model($sformatf("stream%0d", i));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check_model("idle0");
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check_model("idle1");

    // Flush at count 5 with push and pop requested
    chk("preflush.count", W'(count), W'(5));
    saved_pid = pop_id_r;
    step(1'b1, 1'b1, 32'h3FF, 1'b1);
    chk("flush.count", W'(count), W'(0));
    chk("flush.out_valid", W'(out_valid), W'(0));
    chk("flush.pop_valid", W'(pop_valid_r), W'(0));
    chk("flush.pop_id", W'(pop_id_r), W'(saved_pid));
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("postflush.pop_valid", W'(pop_valid_r), W'(0));
    chk("postflush.pop_id", W'(pop_id_r), W'(saved_pid));
    check_model("postflush");

`ifdef ORDER_QUEUE_PEEK_EN
    step(1'b0, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b1, 32'h21, 1'b0);
    chk("peek.valid", W'(peek_valid), W'(1));
    chk("peek.id", W'(peek_order[255:224]), W'(32'h21));
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("peek_pop.valid", W'(peek_valid), W'(0));
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_model("peek_drain");
`endif

    // Reset mid-operation
    step(1'b0, 1'b1, 32'h400, 1'b0);
    step(1'b0, 1'b1, 32'h401, 1'b1);
    step(1'b0, 1'b1, 32'h402, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check_model("pre_reset");
    do_reset("midreset");
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_model("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/order_queue.md
Name: order_queue

Overview:
- Parametrised single-clock successor to the accelerator's dual-entry order cache.
- Buffers packed layer orders (opcode, addresses, patch counts, quant sizes, id, ...) between the host-side order decoder and the layer scheduler in the system_clk domain.
- Adds over the previous generation:
  - configurable width and depth;
  - first-word-fall-through valid/ready output;
  - occupancy count and programmable almost-full;
  - synchronous flush;
  - registered last-popped id for completion reporting.

Parameters:
- ORDER_W, 256: packed order word width in bits.
- DEPTH, 16: entries; power of two, at least 2.
- AF_MARGIN, 2: almost_full asserts when count >= DEPTH-AF_MARGIN; range 0..DEPTH-1.
- ID_LSB, 224: bit position of the 32-bit id field inside the order word.

Ports:
- system_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all queued orders.
- in_valid  in  1  producer has an order.
- in_ready  out  1  queue can accept; equals count < DEPTH.
- in_order  in  ORDER_W  packed order word.
- out_valid  out  1  head order available.
- out_ready  in  1  scheduler consumes head.
- out_order  out  ORDER_W  head order word, stable while out_valid && !out_ready.
- count  out  $clog2(DEPTH)+1  entries held, including the head register.
- almost_full  out  1  count >= DEPTH-AF_MARGIN.
- empty  out  1  count == 0.
- pop_valid_r  out  1  one-cycle pulse, one cycle after each pop.
- pop_id_r  out  32  id of the most recently popped order.

Behaviour:
- Interface: one clock, system_clk; reset rst is synchronous and active-high.
- Reset: clears pointers and count. Output values after reset:
  - out_valid=0, out_order=0;
  - in_ready=1, empty=1, almost_full=0;
  - pop_valid_r=0, pop_id_r=0.
- Push and pop conditions:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - No other qualifier applies.
- Latency:
  - A push into an empty queue at edge N gives out_valid=1 with that word after edge N (next cycle).
  - Back-to-back pops sustain 1 order/cycle while entries are present.
- Ordering: strict FIFO; no reordering.
- Storage: DEPTH-1 entries in RAM plus one head output register. RAM read is registered, so the head register must be prefetched so that pop plus refill happen in the same cycle with no bubble.
- Count arithmetic:
  - count += push, -= pop, computed in the same cycle.
  - Pointers are $clog2(DEPTH)-1..0 wide and wrap modulo DEPTH with no special case.
- Full boundary:
  - in_ready is derived from the registered count.
  - At count==DEPTH a push in the same cycle as a pop is NOT accepted, because in_ready=0. Producer retries next cycle.
- Empty boundary:
  - At count==0 out_valid=0 and out_ready is ignored.
  - A push and a pop cannot coincide on the same word.
- Simultaneous push and pop at 0<count<DEPTH: count unchanged, both take effect.
- almost_full: combinational from registered count. With AF_MARGIN=0 it equals full.
- Flush:
  - The next edge clears pointers and count, and out_valid falls to 0.
  - Flush has priority: push and pop in the same cycle are both dropped, and pop_valid_r does not pulse.
  - pop_id_r holds its value.
- Pop report:
  - On pop at edge N, after edge N+1: pop_valid_r=1 and pop_id_r=out_order[ID_LSB+31:ID_LSB] as captured at edge N.
  - pop_valid_r is 0 in any cycle without a preceding pop.
- Reset mid-operation: identical to flush, and additionally clears pop_id_r and pop_valid_r. Queued data is lost.
- out_order contents in RAM while empty are don't-care; out_order itself holds its last value while out_valid=0.

Optional Feature:
- Macro: ORDER_QUEUE_PEEK_EN.
- When defined:
  - Adds outputs peek_valid (1) and peek_order (ORDER_W), exposing the second-oldest entry so the scheduler can prefetch weights for the next layer.
  - peek_valid = count >= 2.
  - peek_order updates in the same cycle as out_order, with the same prefetch rule.
  - Flush and reset clear peek_valid.
- When undefined: ports absent, no extra read port or register.

Decomposition:
- Shared package order_pkg holds:
  - ORDER_W default;
  - field LSB/width constants for every order field (order[2:0] at 0, feature_input_base_addr at 3, ..., id at 224);
  - opcode localparams.
- Natural sub-module: order_queue_ram, a simple dual-port RAM of DEPTH-1 x ORDER_W with registered read. With ORDER_QUEUE_PEEK_EN it gains a second read port.
- Head/prefetch control and counters stay in order_queue.

Test Plan:
- Reset, then push 3 orders with ids 0x10,0x11,0x12 while out_ready=0 -> count=3, out_valid=1, out_order id 0x10 held stable.
- out_ready=1 for 3 cycles -> pops in order 0x10,0x11,0x12, one per cycle. pop_valid_r pulses 3 cycles, one cycle late, with pop_id_r tracking each id. Ends empty=1.
- DEPTH=16, AF_MARGIN=2: push 14 -> almost_full=1, in_ready=1. Push 16 -> in_ready=0. Push+pop at count 16 -> push rejected, count=15.
- Steady stream, in_valid=out_ready=1 for 100 cycles -> 100 orders pass with no bubble after the first. Count constant; pointers wrap through index 0 at least 6 times.
- count=5, flush asserted together with in_valid and out_ready -> next cycle count=0, out_valid=0, no pop_valid_r pulse, pop_id_r unchanged.
- With ORDER_QUEUE_PEEK_EN: push ids 0x20,0x21 -> peek_valid=1, peek id 0x21. Pop once -> peek_valid=0.
